// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and default sizing for the AXI-Stream packet generator.
package axis_pkt_gen_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream output bundle of the packet generator (tdata/tvalid/tlast/tready).
interface axis_pkt_gen_if
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/stream_fifo_mem.sv
// Circular FIFO storage with wrapping pointers and occupancy count; read data is
// presented combinationally from the read pointer.
module stream_fifo_mem
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              wr_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rptr];

  // storage is deliberately left out of reset; only pointers and count are cleared
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// Buffers pushed words and emits them as AXI-Stream packets of pkt_len beats
// (pkt_len==0: drain mode). Define AXIS_PKT_GEN_STATS_EN to enable the pkt_cnt counter.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   din,
  input  logic                push,
  input  logic                op_en,
  input  logic [CNT_W-1:0]    pkt_len,
  axis_pkt_gen_if.master      axis,
  output logic [CNT_W-1:0]    buff_count,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic [15:0]         pkt_cnt
);

  state_t            state_q, state_d;
  logic              load;
  logic              start;
  logic              wr_ok;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  beat_cnt, len_q;
  logic [CNT_W-1:0]  beat_nxt, len_nxt;
  logic              last_nxt;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              last_p1;

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push),
    .din   (din),
    .rd_en (load),
    .dout  (fifo_dout),
    .count (buff_count),
    .empty (empty),
    .full  (full),
    .wr_ok (wr_ok)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_en && !empty) begin
          load    = 1'b1;
          start   = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (axis.tready) begin
          if (last_p1) begin
            if (op_en && !empty) begin
              load  = 1'b1;
              start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    beat_nxt = start ? CNT_W'(1) : beat_cnt + CNT_W'(1);
    len_nxt  = start ? pkt_len : len_q;
    // drain mode closes the packet when the beat being loaded empties the FIFO
    if (len_nxt != '0) last_nxt = (beat_nxt == len_nxt);
    else               last_nxt = (buff_count == CNT_W'(1)) && !wr_ok;
  end

  // stage p1: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      data_p1  <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= (state_d == ACTIVE);
      if (load) begin
        data_p1  <= fifo_dout;
        last_p1  <= last_nxt;
        beat_cnt <= beat_nxt;
        len_q    <= len_nxt;
      end
    end
  end

  assign axis.tdata  = data_p1;
  assign axis.tvalid = vld_p1;
  assign axis.tlast  = last_p1;

  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (push && full) overflow <= 1'b1;
  end

`ifdef AXIS_PKT_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                  pkt_cnt <= '0;
    else if (vld_p1 && axis.tready && last_p1) pkt_cnt <= pkt_cnt + 16'd1;
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the FIFO entry count; it SHALL be a power of two, minimum 2.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(DEPTH)+1, meaning the width of the count and length fields; it SHALL be derived and never overridden.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port din, input, DATA_W bits: write data.
REQ-007 The block SHALL have port push, input, 1 bit: write request.
REQ-008 The block SHALL have port op_en, input, 1 bit: output enable, which permits new packets to start.
REQ-009 The block SHALL have port pkt_len, input, CNT_W bits: beats per packet; 0 selects drain mode.
REQ-010 The block SHALL have port tready, input, 1 bit: sink ready.
REQ-011 The block SHALL have port tdata, output, DATA_W bits: stream data.
REQ-012 The block SHALL have port tvalid, output, 1 bit: stream valid.
REQ-013 The block SHALL have port tlast, output, 1 bit: last beat of packet.
REQ-014 The block SHALL have port buff_count, output, CNT_W bits: FIFO occupancy, excluding the output register.
REQ-015 The block SHALL have ports empty and full, outputs, 1 bit each: empty asserted when buff_count==0, full asserted when buff_count==DEPTH.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag set by a push while full.
REQ-017 The block SHALL have port pkt_cnt, output, 16 bits: completed-packet counter (see Configuration).

Function
REQ-018 The FIFO SHALL be circular; wptr and rptr SHALL be log2(DEPTH) bits and wrap DEPTH-1->0, with no pointer resets outside rst.
REQ-019 A write SHALL be accepted when push && !full, regardless of op_en; the data is readable on the next cycle.
REQ-020 A push while full SHALL drop din, leave the FIFO unchanged and set overflow.
REQ-021 A simultaneous accepted write and read SHALL leave buff_count unchanged.
REQ-022 The output register SHALL load when the FSM permits and (!tvalid || tready) && !empty; a load decrements buff_count.
REQ-023 While tvalid && !tready, tdata, tvalid and tlast SHALL hold stable.
REQ-024 The FSM SHALL have three states: IDLE (tvalid=0), ACTIVE (tvalid=1) and STALL (mid-packet with FIFO empty, tvalid=0).
REQ-025 IDLE SHALL go to ACTIVE when op_en && !empty: load the first beat, latch pkt_len into len_q and set beat_cnt to 1.
REQ-026 On an ACTIVE handshake with tlast=1, the FSM SHALL start a new packet (per REQ-025) if op_en && !empty, else go to IDLE.
REQ-027 On an ACTIVE handshake with tlast=0, the FSM SHALL load the next beat and increment beat_cnt if !empty, else go to STALL.
REQ-028 STALL SHALL go to ACTIVE when !empty, loading the next beat; op_en is ignored mid-packet.
REQ-029 Deasserting op_en SHALL take effect only at a packet boundary.
REQ-030 With len_q!=0, tlast SHALL be set on the loaded beat whose beat number equals len_q.
REQ-031 With len_q==0 (drain mode), tlast SHALL be set on the beat loaded when buff_count==1 and no write is accepted that cycle; STALL is unreachable in drain mode.
REQ-032 Latency SHALL be: push at edge N gives earliest tvalid after edge N+1 (with op_en high, state IDLE).

Reset
REQ-033 When rst is high at a clock edge, the block SHALL clear tvalid, tlast, tdata, buff_count, pointers, beat_cnt, len_q, overflow and pkt_cnt; set empty=1 and full=0; and enter IDLE.
REQ-034 Reset mid-packet SHALL discard the in-flight beat and all FIFO contents; the memory array itself is not cleared.

Configuration
REQ-035 With AXIS_PKT_GEN_STATS_EN defined, pkt_cnt SHALL increment (wrapping at 16 bits) on each handshake with tlast=1.
REQ-036 Without AXIS_PKT_GEN_STATS_EN, pkt_cnt SHALL be driven constant 0 and no counter logic is synthesised.

Structure
REQ-037 Package axis_pkt_gen_pkg SHALL hold the FSM state enum (IDLE, ACTIVE, STALL) and the default DATA_W/DEPTH constants.
REQ-038 Sub-module stream_fifo_mem SHALL hold the storage array, pointers and count; the FSM and output register stay in axis_pkt_gen.

Verification
REQ-039 Scenario: pkt_len=4, op_en=0, push 0x10..0x17, then op_en=1 with tready=1 -> two packets of 4 beats each, tlast on 0x13 and 0x17, pkt_cnt=2 (STATS_EN).
REQ-040 Scenario: DEPTH=16, 17 pushes with op_en=0 -> full=1, buff_count=16, overflow=1, 17th datum never appears on tdata.
REQ-041 Scenario: pkt_len=3, push 2 beats, op_en=1 -> 2 beats with tlast=0, then STALL with tvalid=0; push 1 more -> third beat with tlast=1.
REQ-042 Scenario: tready toggled 1/0 every cycle during a 5-beat packet -> tdata/tlast are stable while stalled, and no beat is lost or duplicated.
REQ-043 Scenario: pkt_len=0, preload 3 beats, no further push -> 3 beats with tlast only on the third; 40 push/pop cycles cause pointer wrap with data order preserved.
REQ-044 Scenario: rst asserted during beat 2 of 4 -> next cycle tvalid=0, empty=1, buff_count=0, overflow=0.
